bt_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver in bt_control.
- Consumes received bytes (data plus done strobe) from the Bluetooth module link.
- Frames them into fixed 4-byte command packets, checks each packet and presents validated command/argument pairs to the game-control logic.
- Flags malformed or stalled packets and keeps a saturating error count.

---
 rtl/bt_cmd_parser_pkg.sv | 41 ++++
 rtl/bt_cmd_parser_timeout_ctr.sv | 42 ++++
 rtl/bt_cmd_parser.sv | 143 ++++++++++++++
 tb/tb_bt_cmd_parser.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_cmd_parser_pkg.sv
// -----------------------------------------------------------------------------
// bt_cmd_parser_pkg
// Shared definitions for the Bluetooth control path: parser FSM state
// encoding, discard reason codes, the default packet sync marker and the
// command opcodes understood by the game-control consumer.
// -----------------------------------------------------------------------------
package bt_cmd_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_CMD = 2'd1,
    ST_GET_ARG = 2'd2,
    ST_GET_CHK = 2'd3
  } bt_state_e;

  // Reason for the most recent discarded packet.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  // Command opcodes shared with the game-control logic.
  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;
  localparam logic [7:0] CMD_LEFT  = 8'h03;
  localparam logic [7:0] CMD_RIGHT = 8'h04;
  localparam logic [7:0] CMD_FIRE  = 8'h05;

  // Packet check byte: XOR of command and argument.
  function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd ^ arg;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bt_cmd_parser_timeout_ctr.sv
// -----------------------------------------------------------------------------
// bt_timeout_ctr
// Clear/enable up-counter with a terminal-count flag. Clear has priority over
// enable. o_tc is high while the count equals TERM-1, so a caller that clears
// on o_tc sees a period of exactly TERM enabled cycles.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_clr    synchronous clear (priority)
//   i_en     count enable
//   o_tc     terminal count reached (count == TERM-1)
// -----------------------------------------------------------------------------
module bt_timeout_ctr #(
  parameter int TERM = 25000,
  parameter int W    = $clog2(TERM + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_count;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation that does not match the synthesized hardware.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == W'(TERM - 1));

endmodule

// File: rtl/bt_cmd_parser.sv
// -----------------------------------------------------------------------------
// bt_cmd_parser
// Frames UART bytes into 4-byte packets {SYNC, CMD, ARG, CHK=CMD^ARG},
// publishes validated command/argument pairs and counts discarded packets
// (bad check byte or inter-byte silence mid-packet).
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_data[7:0]   received byte, valid while i_done is high
//   i_done        byte-received strobe, may last several cycles
//   o_cmd[7:0]    command of the last good packet
//   o_arg[7:0]    argument of the last good packet
//   o_cmd_valid   one-cycle pulse when o_cmd/o_arg update
//   o_err         one-cycle pulse when a packet is discarded
//   o_err_code    reason of the last discard (01 checksum, 10 timeout)
//   o_err_count   discard count, saturating at 255
// -----------------------------------------------------------------------------
module bt_cmd_parser
  import bt_cmd_parser_pkg::*;
#(
  parameter int         CLK_FREQ      = 12000000,
  parameter int         BAUD          = 9600,
  parameter int         TIMEOUT_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_done,
  output logic [7:0] o_cmd,
  output logic [7:0] o_arg,
  output logic       o_cmd_valid,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_err_count
);

  // Silence allowed between bytes of one packet, in clock cycles.
  localparam int TIMEOUT_CLKS = (CLK_FREQ / BAUD) * 10 * TIMEOUT_BYTES;
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  bt_state_e  r_state;
  logic       r_done_d;
  logic [7:0] r_cmd_buf;
  logic [7:0] r_arg_buf;
  logic [7:0] r_cmd;
  logic [7:0] r_arg;
  logic       r_cmd_valid;
  logic       r_err;
  logic [1:0] r_err_code;
  logic [7:0] r_err_count;

  logic w_byte_evt;
  logic w_busy;
  logic w_tc;
  logic w_timeout;

  // Rising edge of i_done: a strobe held for several cycles is one byte.
  assign w_byte_evt = i_done & ~r_done_d;
  assign w_busy     = (r_state != ST_IDLE);
  // A byte landing on the terminal-count cycle wins over the timeout.
  assign w_timeout  = w_busy & w_tc & ~w_byte_evt;

  bt_timeout_ctr #(
    .TERM (TIMEOUT_CLKS),
    .W    (TW)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_byte_evt | ~w_busy | w_timeout),
    .i_en    (w_busy),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= i_done;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the async reset also drops any half-received packet, so every
      // register, including the CMD/ARG holding buffers, is cleared here.
      r_state     <= ST_IDLE;
      r_cmd_buf   <= 8'h00;
      r_arg_buf   <= 8'h00;
      r_cmd       <= 8'h00;
      r_arg       <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_count <= 8'h00;
    end else begin
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_byte_evt) begin
        case (r_state)
          ST_IDLE: begin
            // Anything other than the marker is line noise; drop silently.
            if (i_data == SYNC_BYTE) r_state <= ST_GET_CMD;
          end
          ST_GET_CMD: begin
            r_cmd_buf <= i_data;
            r_state   <= ST_GET_ARG;
          end
          ST_GET_ARG: begin
            r_arg_buf <= i_data;
            r_state   <= ST_GET_CHK;
          end
          ST_GET_CHK: begin
            r_state <= ST_IDLE;
            if (i_data == calc_chk(r_cmd_buf, r_arg_buf)) begin
              r_cmd       <= r_cmd_buf;
              r_arg       <= r_arg_buf;
              r_cmd_valid <= 1'b1;
            end else begin
              r_err       <= 1'b1;
              r_err_code  <= ERR_CHK;
              r_err_count <= sat_inc8(r_err_count);
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_err       <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_err_count <= sat_inc8(r_err_count);
      end
    end
  end

  assign o_cmd       = r_cmd;
  assign o_arg       = r_arg;
  assign o_cmd_valid = r_cmd_valid;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_bt_cmd_parser
// Self-checking bench for bt_cmd_parser at default parameters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bt_cmd_parser;

  localparam logic [7:0] SYNC    = 8'hAA;
  localparam int         TO_CLKS = 25000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       done  = 1'b0;

  logic [7:0] o_cmd;
  logic [7:0] o_arg;
  logic       o_cmd_valid;
  logic       o_err;
  logic [1:0] o_err_code;
  logic [7:0] o_err_count;

  bt_cmd_parser dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_done      (done),
    .o_cmd       (o_cmd),
    .o_arg       (o_arg),
    .o_cmd_valid (o_cmd_valid),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- output monitor (samples on the falling edge) ------------
  typedef struct packed {
    logic       is_err;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [1:0] code;
    logic [7:0] cnt;
  } evt_t;

  int   n_valid = 0;
  int   n_err   = 0;
  int   n_both  = 0;
  bit   mon_en  = 1'b0;
  evt_t obs_q[$];

  always @(negedge clk) begin
    if (o_cmd_valid) n_valid++;
    if (o_err) n_err++;
    if (o_cmd_valid && o_err) n_both++;
    if (mon_en && (o_cmd_valid || o_err))
      obs_q.push_back('{o_err, o_cmd, o_arg, o_err_code, o_err_count});
  end

  // ---------------- packet-level reference model ----------------------------
  logic [7:0] m_pkt[$];
  logic [7:0] m_cmd, m_arg, m_cnt;
  logic [1:0] m_code;
  evt_t       exp_q[$];

  function automatic void model_reset();
    m_pkt.delete();
    exp_q.delete();
    m_cmd  = 8'h00;
    m_arg  = 8'h00;
    m_cnt  = 8'h00;
    m_code = 2'b00;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_pkt.size() == 0) begin
      if (b == SYNC) m_pkt.push_back(b);
    end else begin
      m_pkt.push_back(b);
      if (m_pkt.size() == 4) begin
        if ((m_pkt[1] ^ m_pkt[2]) == m_pkt[3]) begin
          m_cmd = m_pkt[1];
          m_arg = m_pkt[2];
          exp_q.push_back('{1'b0, m_cmd, m_arg, m_code, m_cnt});
        end else begin
          m_code = 2'b01;
          if (m_cnt < 8'hFF) m_cnt = m_cnt + 8'd1;
          exp_q.push_back('{1'b1, m_cmd, m_arg, m_code, m_cnt});
        end
        m_pkt.delete();
      end
    end
  endfunction

  // ---------------- stimulus helpers (called on a falling edge) -------------
  task automatic send_byte(input logic [7:0] b, input int width, input int gap);
    data = b;
    done = 1'b1;
    repeat (width) @(negedge clk);
    done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    int         width;
    bit         exp_valid;
    logic [7:0] exp_cmd, exp_arg;
    logic [1:0] exp_code;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, e0, k;
    logic [7:0] stream[$];

    // Expected values follow from the packet rules, starting from the state
    // left by the 1250-cycle good packet (cmd 01, arg 05, no errors yet).
    vecs[0] = '{8'hAA, 8'h01, 8'h05, 8'h00, 1, 1'b0, 8'h01, 8'h05, 2'b01, 8'd1};
    vecs[1] = '{8'hAA, 8'h02, 8'h03, 8'h01, 1, 1'b1, 8'h02, 8'h03, 2'b01, 8'd1};
    vecs[2] = '{8'hAA, 8'hAA, 8'h00, 8'hAA, 1, 1'b1, 8'hAA, 8'h00, 2'b01, 8'd1};
    vecs[3] = '{8'hAA, 8'h10, 8'h20, 8'h30, 1, 1'b1, 8'h10, 8'h20, 2'b01, 8'd1};
    vecs[4] = '{8'hAA, 8'hFF, 8'hFF, 8'h01, 1, 1'b0, 8'h10, 8'h20, 2'b01, 8'd2};
    vecs[5] = '{8'hAA, 8'h04, 8'h04, 8'h00, 3, 1'b1, 8'h04, 8'h04, 2'b01, 8'd2};
    vecs[6] = '{8'hAA, 8'h01, 8'h05, 8'h04, 2, 1'b1, 8'h01, 8'h05, 2'b01, 8'd2};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_cmd",   o_cmd,       8'h00);
    check("rst_arg",   o_arg,       8'h00);
    check("rst_valid", o_cmd_valid, 1'b0);
    check("rst_err",   o_err,       1'b0);
    check("rst_code",  o_err_code,  2'b00);
    check("rst_count", o_err_count, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- good packet, 1250 cycles between bytes, latency of the pulse ----
    v0 = n_valid; e0 = n_err;
    send_byte(8'hAA, 1, 1249);
    send_byte(8'h01, 1, 1249);
    send_byte(8'h05, 1, 1249);
    data = 8'h04; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("good_valid_next_cycle", o_cmd_valid, 1'b1);
    check("good_cmd", o_cmd, 8'h01);
    check("good_arg", o_arg, 8'h05);
    @(negedge clk);
    check("good_valid_one_cycle", o_cmd_valid, 1'b0);
    repeat (2) @(negedge clk);
    check("good_valid_pulses", n_valid - v0, 1);
    check("good_err_pulses",   n_err - e0,   0);

    // ---- table-driven packets ----
    for (int i = 0; i < 7; i++) begin
      v0 = n_valid; e0 = n_err;
      send_byte(vecs[i].b0, vecs[i].width, 2);
      send_byte(vecs[i].b1, vecs[i].width, 2);
      send_byte(vecs[i].b2, vecs[i].width, 2);
      send_byte(vecs[i].b3, vecs[i].width, 3);
      check($sformatf("vec%0d_valid_pulses", i), n_valid - v0, vecs[i].exp_valid ? 1 : 0);
      check($sformatf("vec%0d_err_pulses", i),   n_err - e0,   vecs[i].exp_valid ? 0 : 1);
      check($sformatf("vec%0d_cmd", i),   o_cmd,       vecs[i].exp_cmd);
      check($sformatf("vec%0d_arg", i),   o_arg,       vecs[i].exp_arg);
      check($sformatf("vec%0d_code", i),  o_err_code,  vecs[i].exp_code);
      check($sformatf("vec%0d_count", i), o_err_count, vecs[i].exp_cnt);
    end

    // ---- leading junk before a packet ----
    v0 = n_valid; e0 = n_err;
    send_byte(8'h55, 1, 1);
    send_byte(8'h13, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h03, 1, 1);
    send_byte(8'h01, 1, 3);
    check("junk_valid_pulses", n_valid - v0, 1);
    check("junk_err_pulses",   n_err - e0,   0);
    check("junk_cmd", o_cmd, 8'h02);
    check("junk_arg", o_arg, 8'h03);

    // ---- timeout: error exactly TO_CLKS edges after the CMD byte edge ----
    v0 = n_valid;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 0);
    k = 0;
    while (o_err !== 1'b1 && k < TO_CLKS + 5000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, TO_CLKS);
    check("timeout_code",  o_err_code,  2'b10);
    check("timeout_count", o_err_count, 8'd3);
    check("timeout_no_valid", n_valid - v0, 0);
    @(negedge clk);
    check("timeout_err_one_cycle", o_err, 1'b0);
    v0 = n_valid;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h07, 1, 1);
    send_byte(8'h00, 1, 1);
    send_byte(8'h07, 1, 3);
    check("after_timeout_valid", n_valid - v0, 1);
    check("after_timeout_cmd", o_cmd, 8'h07);
    check("after_timeout_arg", o_arg, 8'h00);

    // ---- byte captured on the terminal-count cycle beats the timeout ----
    v0 = n_valid; e0 = n_err;
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 0);
    repeat (TO_CLKS - 1) @(negedge clk);
    send_byte(8'h05, 1, 1);
    send_byte(8'h04, 1, 3);
    check("boundary_err_pulses",   n_err - e0,   0);
    check("boundary_valid_pulses", n_valid - v0, 1);
    check("boundary_arg",   o_arg,       8'h05);
    check("boundary_count", o_err_count, 8'd3);

    // ---- asynchronous reset mid-packet ----
    send_byte(8'hAA, 1, 1);
    send_byte(8'h01, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cmd",   o_cmd,       8'h00);
    check("midrst_arg",   o_arg,       8'h00);
    check("midrst_code",  o_err_code,  2'b00);
    check("midrst_count", o_err_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v0 = n_valid; e0 = n_err;
    send_byte(8'h05, 1, 1);
    send_byte(8'h04, 1, 3);
    check("midrst_ignored_valid", n_valid - v0, 0);
    check("midrst_ignored_err",   n_err - e0,   0);
    check("midrst_ignored_cmd",   o_cmd,        8'h00);

    // ---- randomized byte stream against the packet model ----
    do_reset();
    model_reset();
    obs_q.delete();
    for (int p = 0; p < 150; p++) begin
      logic [7:0] c, a;
      int sel;
      c = 8'($urandom);
      a = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        stream.push_back(SYNC); stream.push_back(c); stream.push_back(a); stream.push_back(c ^ a);
      end else if (sel <= 6) begin
        stream.push_back(SYNC); stream.push_back(c); stream.push_back(a);
        stream.push_back(c ^ a ^ 8'($urandom_range(1, 255)));
      end else if (sel == 7) begin
        stream.push_back(c);
      end else begin
        for (int j = 0; j < 4; j++) stream.push_back(8'($urandom));
      end
    end
    mon_en = 1'b1;
    foreach (stream[i]) begin
      model_byte(stream[i]);
      send_byte(stream[i], $urandom_range(1, 3), $urandom_range(1, 3));
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("rand_event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("rand_event%0d", i), obs_q[i], exp_q[i]);

    // ---- error count saturation ----
    do_reset();
    v0 = n_valid; e0 = n_err;
    for (int p = 0; p < 300; p++) begin
      send_byte(8'hAA, 1, 1);
      send_byte(8'h01, 1, 1);
      send_byte(8'h02, 1, 1);
      send_byte(8'h00, 1, 1);
    end
    repeat (3) @(negedge clk);
    check("sat_count",      o_err_count, 8'hFF);
    check("sat_err_pulses", n_err - e0,  300);
    check("sat_no_valid",   n_valid - v0, 0);
    check("sat_code",       o_err_code,  2'b01);
    check("sat_cmd_held",   o_cmd,       8'h00);

    check("valid_and_err_never_together", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
